player_missile: RTL and testbench



---
 rtl/player_missile_if.sv | 26 ++
 rtl/player_missile.sv | 130 +++++++++++++
 tb/tb_player_missile.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/player_missile_if.sv
// Missile bus between the player/keyboard side, the missile owner and the alien array.
// master = the missile itself; slave = the logic that supplies player state and consumes missile coordinates.
interface player_missile_if #(
    parameter int NUM_ALIENS = 10
);
    logic                  fire;
    logic [9:0]            PlayerX;
    logic [9:0]            PlayerY;
    logic [9:0]            PlayerW;
    logic [NUM_ALIENS-1:0] hit_vec;
    logic [9:0]            MissileX;
    logic [9:0]            MissileY;
    logic [9:0]            MissileS;
    logic                  active;
    logic                  kill_strobe;

    modport master (
        input  fire, PlayerX, PlayerY, PlayerW, hit_vec,
        output MissileX, MissileY, MissileS, active, kill_strobe
    );

    modport slave (
        output fire, PlayerX, PlayerY, PlayerW, hit_vec,
        input  MissileX, MissileY, MissileS, active, kill_strobe
    );
endinterface

// File: rtl/player_missile.sv
// Single player shot: launches on a fire-key edge, climbs STEP pixels per frame,
// retires on a fresh alien hit or at the top of the screen, then waits out a cooldown.
module player_missile #(
    parameter int NUM_ALIENS = 10,
    parameter int MISSILE_W  = 3,
    parameter int MISSILE_H  = 6,
    parameter int STEP       = 4,
    parameter int Y_MIN      = 0,
    parameter int COOLDOWN   = 8,
    parameter int PARK_X     = 0,
    parameter int PARK_Y     = 1023
) (
    input  logic              frame_clk,
    input  logic              Reset,
    player_missile_if.master  bus
);
    localparam int CNT_W = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;

    localparam logic [9:0]       PARK_X_C    = 10'(PARK_X);
    localparam logic [9:0]       PARK_Y_C    = 10'(PARK_Y);
    localparam logic [9:0]       STEP_C      = 10'(STEP);
    localparam logic [10:0]      TOP_LIMIT_C = 11'(Y_MIN + STEP);
    localparam logic [CNT_W-1:0] COOL_LOAD_C = CNT_W'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FLYING,
        COOL
    } state_t;

    state_t                state_q, state_d;
    logic [9:0]            x_q, x_d;
    logic [9:0]            y_q, y_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  kill_q, kill_d;
    logic                  fire_prev_q;
    logic [NUM_ALIENS-1:0] hit_prev_q;

    logic                  fire_rise;
    logic                  new_hit;
    logic [9:0]            launch_x;
    logic [9:0]            launch_y;

    assign fire_rise = bus.fire & ~fire_prev_q;
    assign new_hit   = |(bus.hit_vec & ~hit_prev_q);

    // Centre the shot on the ship; wrap-around on underflow is intentional 10-bit arithmetic.
    assign launch_x = bus.PlayerX + (bus.PlayerW >> 1) - 10'(MISSILE_W >> 1);
    assign launch_y = bus.PlayerY - 10'(MISSILE_H);

    // Async reset so a mid-flight reset parks the missile without waiting for vsync.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            x_q         <= PARK_X_C;
            y_q         <= PARK_Y_C;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            fire_prev_q <= 1'b0;
            hit_prev_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            fire_prev_q <= bus.fire;
            hit_prev_q  <= bus.hit_vec;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        kill_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fire_rise) begin
                    state_d = FLYING;
                    x_d     = launch_x;
                    y_d     = launch_y;
                end else begin
                    x_d = PARK_X_C;
                    y_d = PARK_Y_C;
                end
            end

            FLYING: begin
                // A hit wins over the top-of-screen exit so a simultaneous event strobes once.
                if (new_hit) begin
                    kill_d  = 1'b1;
                    state_d = COOL;
                    cnt_d   = COOL_LOAD_C;
                    x_d     = PARK_X_C;
                    y_d     = PARK_Y_C;
                end else if ({1'b0, y_q} < TOP_LIMIT_C) begin
                    state_d = COOL;
                    cnt_d   = COOL_LOAD_C;
                    x_d     = PARK_X_C;
                    y_d     = PARK_Y_C;
                end else begin
                    y_d = y_q - STEP_C;
                end
            end

            COOL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                x_d     = PARK_X_C;
                y_d     = PARK_Y_C;
            end
        endcase
    end

    assign bus.MissileX    = x_q;
    assign bus.MissileY    = y_q;
    assign bus.MissileS    = 10'(MISSILE_W);
    assign bus.active      = (state_q == FLYING);
    assign bus.kill_strobe = kill_q;
endmodule

// File: tb/tb_player_missile.sv
// Directed bench for player_missile: expected missile bus values are queued per frame
// and compared just after each frame_clk edge (or immediately for async reset).
module tb_player_missile;
    localparam logic [9:0] PX = 10'd0;
    localparam logic [9:0] PY = 10'd1023;
    localparam logic [9:0] SZ = 10'd3;

    logic frame_clk = 1'b0;
    logic Reset;

    player_missile_if #(.NUM_ALIENS(10)) bus ();

    player_missile dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.master)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        string      tag;
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       kill;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic act, input logic kill);
        exp_t e;
        e.tag  = tag;
        e.x    = x;
        e.y    = y;
        e.act  = act;
        e.kill = kill;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (bus.MissileX === e.x) else begin
                n_fail++;
                $error("FAIL %s MissileX observed=%0d expected=%0d", e.tag, bus.MissileX, e.x);
            end
            n_assert++;
            assert (bus.MissileY === e.y) else begin
                n_fail++;
                $error("FAIL %s MissileY observed=%0d expected=%0d", e.tag, bus.MissileY, e.y);
            end
            n_assert++;
            assert (bus.active === e.act) else begin
                n_fail++;
                $error("FAIL %s active observed=%b expected=%b", e.tag, bus.active, e.act);
            end
            n_assert++;
            assert (bus.kill_strobe === e.kill) else begin
                n_fail++;
                $error("FAIL %s kill_strobe observed=%b expected=%b", e.tag, bus.kill_strobe, e.kill);
            end
            n_assert++;
            assert (bus.MissileS === SZ) else begin
                n_fail++;
                $error("FAIL %s MissileS observed=%0d expected=%0d", e.tag, bus.MissileS, SZ);
            end
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
        check_now();
    endtask

    initial begin
        Reset       = 1'b1;
        bus.fire    = 1'b0;
        bus.PlayerX = 10'd300;
        bus.PlayerY = 10'd440;
        bus.PlayerW = 10'd25;
        bus.hit_vec = '0;

        // Reset state, held across clock edges
        repeat (2) @(posedge frame_clk);
        #1;
        push("reset", PX, PY, 1'b0, 1'b0);
        check_now();
        Reset = 1'b0;
        push("idle", PX, PY, 1'b0, 1'b0);
        tick();

        // Launch 1: X = 300 + 12 - 1, Y = 440 - 6; fire then held for the whole flight
        bus.fire = 1'b1;
        push("launch1", 10'd311, 10'd434, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 108; k++) begin
            if (k == 5) bus.PlayerX = 10'd500;
            push("fly1", 10'd311, 10'(434 - 4 * k), 1'b1, 1'b0);
            tick();
        end
        push("top_exit", PX, PY, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 7; i++) begin
            push("cool1_held", PX, PY, 1'b0, 1'b0);
            tick();
        end
        bus.fire = 1'b0;
        push("cool1_end", PX, PY, 1'b0, 1'b0);
        tick();

        // Fresh press on the first IDLE frame launches (500 + 12 - 1, 446 - 6)
        bus.fire    = 1'b1;
        bus.PlayerY = 10'd446;
        push("launch2", 10'd511, 10'd440, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 35; k++) begin
            bus.fire = (k % 2 == 0);
            push("fly2_repress", 10'd511, 10'(440 - 4 * k), 1'b1, 1'b0);
            tick();
        end

        // Hit at Y=300
        bus.hit_vec[3] = 1'b1;
        push("hit", PX, PY, 1'b0, 1'b1);
        tick();
        for (int i = 1; i <= 9; i++) begin
            bus.fire = (i == 2 || i == 8);
            if (i == 4) bus.hit_vec[0] = 1'b1;
            push("cool2", PX, PY, 1'b0, 1'b0);
            tick();
        end
        bus.fire    = 1'b1;
        bus.PlayerY = 10'd440;
        push("launch3", 10'd511, 10'd434, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 108; k++) begin
            push("fly3", 10'd511, 10'(434 - 4 * k), 1'b1, 1'b0);
            tick();
        end

        // Two hit bits rising on the Y=2 frame: one strobe, one retirement
        bus.hit_vec[5] = 1'b1;
        bus.hit_vec[6] = 1'b1;
        push("hit_top", PX, PY, 1'b0, 1'b1);
        tick();
        push("strobe_once", PX, PY, 1'b0, 1'b0);
        tick();
        for (int i = 2; i <= 8; i++) begin
            push("cool3_held", PX, PY, 1'b0, 1'b0);
            tick();
        end
        push("held_no_fire", PX, PY, 1'b0, 1'b0);
        tick();
        bus.fire = 1'b0;
        push("idle_released", PX, PY, 1'b0, 1'b0);
        tick();
        bus.fire    = 1'b1;
        bus.PlayerY = 10'd406;
        push("launch4", 10'd511, 10'd400, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 50; k++) begin
            push("fly4", 10'd511, 10'(400 - 4 * k), 1'b1, 1'b0);
            tick();
        end

        // Async reset mid-frame at Y=200
        #2;
        Reset = 1'b1;
        #1;
        push("async_reset", PX, PY, 1'b0, 1'b0);
        check_now();
        bus.fire    = 1'b0;
        bus.hit_vec = '0;
        #2;
        Reset = 1'b0;
        push("post_reset_idle", PX, PY, 1'b0, 1'b0);
        tick();
        bus.fire    = 1'b1;
        bus.PlayerX = 10'd300;
        bus.PlayerY = 10'd440;
        push("launch5", 10'd311, 10'd434, 1'b1, 1'b0);
        tick();
        push("fly5", 10'd311, 10'd430, 1'b1, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
